// File: rtl/membank_cfg_pkg.sv
// Shared types and constants for the memory-bank configuration loader.
// The state encoding and the pulse counter width are common to the top and the bench.
package membank_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    PULSE = 3'd2,
    GAP   = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Wide enough for the largest permitted word-line pulse length of 15 cycles
  localparam int PULSE_CNT_W = 4;

endpackage

// File: rtl/membank_cfg_loader_if.sv
// Configuration stream handshake between a bitstream source and the loader.
// The master drives start and the serial data; the slave answers with cfg_ready.
interface membank_cfg_loader_if;
  logic start;
  logic cfg_data;
  logic cfg_valid;
  logic cfg_ready;

  modport master (output start, output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input start, input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/membank_bl_shifter.sv
// Serial-in/parallel-out bit-line register; the first bit shifted in ends at bl[0].
// Contents only move when load_en is high, so bl holds between rows.
module membank_bl_shifter #(
  parameter int BL_WIDTH = 514
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic                din,
  output logic [0:BL_WIDTH-1] bl
);

  // New bits enter at the high index and migrate toward bl[0]
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl <= '0;
    end else if (load_en) begin
      for (int i = 0; i < BL_WIDTH - 1; i++) begin
        bl[i] <= bl[i+1];
      end
      bl[BL_WIDTH-1] <= din;
    end
  end

endmodule

// File: rtl/membank_cfg_loader.sv
// Loads a memory bank row by row: shifts in one row of bit-line data, then pulses
// that row's word line for WL_PULSE cycles followed by a single quiet gap cycle.
module membank_cfg_loader
  import membank_cfg_pkg::*;
#(
  parameter int BL_WIDTH = 514,
  parameter int WL_WIDTH = 407,
  parameter int WL_PULSE = 2
) (
  input  logic                  clk,
  input  logic                  global_resetn,
  membank_cfg_loader_if.slave   cfg,
  output logic [0:BL_WIDTH-1]   bl,
  output logic [0:WL_WIDTH-1]   wl,
  output logic                  busy,
  output logic                  done
);

  localparam int BW = (BL_WIDTH > 1) ? $clog2(BL_WIDTH) : 1;
  localparam int RW = (WL_WIDTH > 1) ? $clog2(WL_WIDTH) : 1;
  localparam logic [BW-1:0]          BIT_LAST   = BW'(BL_WIDTH - 1);
  localparam logic [RW-1:0]          ROW_LAST   = RW'(WL_WIDTH - 1);
  localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(WL_PULSE - 1);

  state_t                 state;
  state_t                 next_state;
  logic [BW-1:0]          bit_cnt;
  logic [RW-1:0]          row;
  logic [PULSE_CNT_W-1:0] pulse_cnt;
  logic                   xfer;

  assign xfer = (state == SHIFT) && cfg.cfg_valid;

  membank_bl_shifter #(.BL_WIDTH(BL_WIDTH)) u_shifter (
    .clk     (clk),
    .rst_n   (global_resetn),
    .load_en (xfer),
    .din     (cfg.cfg_data),
    .bl      (bl)
  );

  always_comb begin
    next_state    = state;
    cfg.cfg_ready = 1'b0;
    busy          = 1'b0;
    case (state)
      IDLE, DONE: if (cfg.start) next_state = SHIFT;
      SHIFT: begin
        cfg.cfg_ready = 1'b1;
        busy          = 1'b1;
        if (xfer && bit_cnt == BIT_LAST) next_state = PULSE;
      end
      PULSE: begin
        busy = 1'b1;
        if (pulse_cnt == PULSE_LAST) next_state = GAP;
      end
      GAP: begin
        busy       = 1'b1;
        next_state = (row == ROW_LAST) ? DONE : SHIFT;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      row       <= '0;
      pulse_cnt <= '0;
      done      <= 1'b0;
    end else begin
      state <= next_state;
      case (state)
        IDLE, DONE: begin
          if (cfg.start) begin
            bit_cnt   <= '0;
            row       <= '0;
            pulse_cnt <= '0;
            done      <= 1'b0;
          end
        end
        SHIFT: begin
          pulse_cnt <= '0;
          if (xfer) bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
        end
        PULSE: pulse_cnt <= pulse_cnt + 1'b1;
        GAP: begin
          pulse_cnt <= '0;
          if (row == ROW_LAST) done <= 1'b1;
          else                 row  <= row + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Word lines come straight from flops, so the strobe cannot glitch
  always_ff @(posedge clk or negedge global_resetn) begin
    if (!global_resetn) begin
      wl <= '0;
    end else begin
      wl <= '0;
      if (next_state == PULSE) wl[row] <= 1'b1;
    end
  end

endmodule
